sha256_compress: RTL and testbench

- Downstream consumer of the expanded message schedule (64 words W[0..63]).
- Runs the 64 SHA-256 compression rounds, one per clock, from a chaining value `prev_hash`.
- Produces the updated 256-bit hash (`prev_hash` + working variables) for the next block or final digest.
- Sits between the W-expansion stage and the top-level block/digest controller.

---
 rtl/sha256_pkg.sv | 59 +++++
 rtl/sha256_round.sv | 42 ++++
 rtl/sha256_compress.sv | 104 ++++++++++
 tb/tb_sha256_compress.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, state encoding and round helper functions
package sha256_pkg;

  localparam int W_LENGTH   = 64;
  localparam int WORD_WIDTH = 32;

  typedef logic [WORD_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_e;

  localparam logic [0:W_LENGTH-1][WORD_WIDTH-1:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [0:7][WORD_WIDTH-1:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_WIDTH - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round
module sha256_round
  import sha256_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] a_i,
  input  logic [WORD_WIDTH-1:0] b_i,
  input  logic [WORD_WIDTH-1:0] c_i,
  input  logic [WORD_WIDTH-1:0] d_i,
  input  logic [WORD_WIDTH-1:0] e_i,
  input  logic [WORD_WIDTH-1:0] f_i,
  input  logic [WORD_WIDTH-1:0] g_i,
  input  logic [WORD_WIDTH-1:0] h_i,
  input  logic [WORD_WIDTH-1:0] k_i,
  input  logic [WORD_WIDTH-1:0] w_i,
  output logic [WORD_WIDTH-1:0] a_o,
  output logic [WORD_WIDTH-1:0] b_o,
  output logic [WORD_WIDTH-1:0] c_o,
  output logic [WORD_WIDTH-1:0] d_o,
  output logic [WORD_WIDTH-1:0] e_o,
  output logic [WORD_WIDTH-1:0] f_o,
  output logic [WORD_WIDTH-1:0] g_o,
  output logic [WORD_WIDTH-1:0] h_o
);

  word_t t1;
  word_t t2;

  always_comb begin
    t1 = h_i + big_sigma1(e_i) + ch(e_i, f_i, g_i) + k_i + w_i;
    t2 = big_sigma0(a_i) + maj(a_i, b_i, c_i);
  end

  assign a_o = t1 + t2;
  assign b_o = a_i;
  assign c_o = b_i;
  assign d_o = c_i;
  assign e_o = d_i + t1;
  assign f_o = e_i;
  assign g_o = f_i;
  assign h_o = g_i;

endmodule

// File: rtl/sha256_compress.sv
// rtl/sha256_compress.sv - 64-round SHA-256 compression, one round per clock
module sha256_compress
  import sha256_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           w_vector_complete,
  input  logic [W_LENGTH*WORD_WIDTH-1:0] w_vector,
  input  logic [8*WORD_WIDTH-1:0]        prev_hash,
  output logic                           busy,
  output logic                           hash_valid,
  output logic [8*WORD_WIDTH-1:0]        hash_out
);

  state_e                  state_q, state_d;
  logic [5:0]              round_q, round_d;
  word_t                   work_q [8];
  word_t                   work_d [8];
  word_t                   rnd_o  [8];
  logic [8*WORD_WIDTH-1:0] hreg_q, hreg_d;
  logic [8*WORD_WIDTH-1:0] hash_out_q, hash_out_d;
  logic                    busy_q, busy_d;
  logic                    hash_valid_q, hash_valid_d;
  word_t                   w_t;

  assign w_t = w_vector[WORD_WIDTH*round_q +: WORD_WIDTH];

  sha256_round u_round (
    .a_i(work_q[0]), .b_i(work_q[1]), .c_i(work_q[2]), .d_i(work_q[3]),
    .e_i(work_q[4]), .f_i(work_q[5]), .g_i(work_q[6]), .h_i(work_q[7]),
    .k_i(K[round_q]),
    .w_i(w_t),
    .a_o(rnd_o[0]), .b_o(rnd_o[1]), .c_o(rnd_o[2]), .d_o(rnd_o[3]),
    .e_o(rnd_o[4]), .f_o(rnd_o[5]), .g_o(rnd_o[6]), .h_o(rnd_o[7])
  );

  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    work_d       = work_q;
    hreg_d       = hreg_q;
    hash_out_d   = hash_out_q;
    busy_d       = busy_q;
    hash_valid_d = hash_valid_q;
    unique case (state_q)
      IDLE: begin
        // Without a complete schedule the request is dropped, not queued.
        if (enable && w_vector_complete) begin
          for (int i = 0; i < 8; i++) begin
            work_d[i] = prev_hash[WORD_WIDTH*(7-i) +: WORD_WIDTH];
          end
          hreg_d       = prev_hash;
          round_d      = '0;
          busy_d       = 1'b1;
          hash_valid_d = 1'b0;
          state_d      = ROUND;
        end
      end
      ROUND: begin
        work_d  = rnd_o;
        round_d = round_q + 6'd1;
        if (round_q == 6'd63) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) begin
          hash_out_d[WORD_WIDTH*(7-i) +: WORD_WIDTH] =
            hreg_q[WORD_WIDTH*(7-i) +: WORD_WIDTH] + work_q[i];
        end
        hash_valid_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      round_q      <= '0;
      work_q       <= '{default: '0};
      hreg_q       <= '0;
      hash_out_q   <= '0;
      busy_q       <= 1'b0;
      hash_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      work_q       <= work_d;
      hreg_q       <= hreg_d;
      hash_out_q   <= hash_out_d;
      busy_q       <= busy_d;
      hash_valid_q <= hash_valid_d;
    end
  end

  assign busy       = busy_q;
  assign hash_valid = hash_valid_q;
  assign hash_out   = hash_out_q;

endmodule

// File: tb/tb_sha256_compress.sv
// tb/tb_sha256_compress.sv - directed and random checks of sha256_compress against a reference model
module tb_sha256_compress;

  logic          clock;
  logic          reset;
  logic          enable;
  logic          w_vector_complete;
  logic [2047:0] w_vector;
  logic [255:0]  prev_hash;
  logic          busy;
  logic          hash_valid;
  logic [255:0]  hash_out;

  int tests_run;
  int tests_failed;

  logic [31:0] msg_blk [4][16];
  int          msg_nblk;

  localparam logic [31:0] TK [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] TB_IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  sha256_compress dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .w_vector_complete(w_vector_complete),
    .w_vector(w_vector),
    .prev_hash(prev_hash),
    .busy(busy),
    .hash_valid(hash_valid),
    .hash_out(hash_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Standard SHA-256 padding of an ASCII message into 512-bit blocks.
  task automatic pad_msg(input string s);
    logic [7:0]  bytes [128];
    logic [63:0] bitlen;
    int          len;
    int          total;
    foreach (bytes[i]) bytes[i] = 8'h00;
    len = s.len();
    for (int i = 0; i < len; i++) bytes[i] = s[i];
    bytes[len] = 8'h80;
    msg_nblk = (len + 8) / 64 + 1;
    total = msg_nblk * 64;
    bitlen = 64'(len * 8);
    for (int i = 0; i < 8; i++) bytes[total-1-i] = bitlen[8*i +: 8];
    for (int b = 0; b < msg_nblk; b++)
      for (int w = 0; w < 16; w++)
        msg_blk[b][w] = {bytes[b*64+4*w], bytes[b*64+4*w+1], bytes[b*64+4*w+2], bytes[b*64+4*w+3]};
  endtask

  function automatic logic [2047:0] expand_blk(input int b);
    logic [31:0]   w [64];
    logic [31:0]   s0, s1;
    logic [2047:0] v;
    for (int t = 0; t < 16; t++) w[t] = msg_blk[b][t];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int t = 0; t < 64; t++) v[32*t +: 32] = w[t];
    return v;
  endfunction

  function automatic logic [255:0] model(input logic [255:0] prev, input logic [2047:0] wv);
    logic [31:0]  v [8];
    logic [31:0]  t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) v[i] = prev[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
           + TK[t] + wv[32*t +: 32];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = prev[255-32*i -: 32] + v[i];
    return r;
  endfunction

  task automatic start_run(input string tag, input logic [255:0] prev, input logic [2047:0] wv);
    @(negedge clock);
    prev_hash = prev;
    w_vector = wv;
    enable = 1'b1;
    w_vector_complete = 1'b1;
    @(posedge clock);
    #1;
    enable = 1'b0;
    check({tag, "_accept_busy"}, 256'(busy), 256'(1'b1));
    check({tag, "_accept_valid_clr"}, 256'(hash_valid), 256'(1'b0));
  endtask

  // Waits for the result (bounded), optionally pulsing enable after cycles p1 and p2.
  task automatic finish_run(input string tag, input logic [255:0] exp, input int p1, input int p2);
    int cycles;
    cycles = 0;
    while (cycles < 200) begin
      @(posedge clock);
      cycles++;
      #1;
      enable = (cycles == p1 || cycles == p2);
      if (hash_valid) break;
    end
    enable = 1'b0;
    check({tag, "_latency"}, 256'(cycles), 256'(65));
    check({tag, "_digest"}, hash_out, exp);
    check({tag, "_busy_low"}, 256'(busy), 256'(1'b0));
  endtask

  initial begin
    logic [2047:0] wv_abc, wv_empty, wv_b1, wv_b2, wv_r;
    logic [255:0]  h1, held, pr;

    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    enable = 1'b0;
    w_vector_complete = 1'b0;
    w_vector = '0;
    prev_hash = '0;

    pad_msg("abc");
    wv_abc = expand_blk(0);
    pad_msg("");
    wv_empty = expand_blk(0);
    pad_msg("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    wv_b1 = expand_blk(0);
    wv_b2 = expand_blk(1);

    repeat (2) @(posedge clock);
    #1;
    check("reset_busy", 256'(busy), 256'(1'b0));
    check("reset_valid", 256'(hash_valid), 256'(1'b0));
    check("reset_hash", hash_out, 256'd0);
    @(negedge clock);
    reset = 1'b0;

    start_run("abc", TB_IV, wv_abc);
    finish_run("abc", D_ABC, -1, -1);

    // Enable without a ready schedule must neither start a run nor disturb the result.
    @(negedge clock);
    enable = 1'b1;
    w_vector_complete = 1'b0;
    held = hash_out;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      check("idle_hold", {hash_out[253:0], busy, hash_valid}, {held[253:0], 1'b0, 1'b1});
    end
    enable = 1'b0;

    start_run("empty", TB_IV, wv_empty);
    finish_run("empty", D_EMPTY, -1, -1);

    h1 = model(TB_IV, wv_b1);
    start_run("two_b1", TB_IV, wv_b1);
    finish_run("two_b1", h1, -1, -1);
    start_run("two_b2", h1, wv_b2);
    finish_run("two_b2", D_TWO, -1, -1);

    start_run("pulse", TB_IV, wv_abc);
    finish_run("pulse", D_ABC, 5, 40);

    start_run("abort", TB_IV, wv_empty);
    repeat (30) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("abort_busy", 256'(busy), 256'(1'b0));
    check("abort_valid", 256'(hash_valid), 256'(1'b0));
    check("abort_hash", hash_out, 256'd0);
    @(negedge clock);
    reset = 1'b0;
    start_run("abc2", TB_IV, wv_abc);
    finish_run("abc2", D_ABC, -1, -1);

    for (int n = 0; n < 5; n++) begin
      for (int w = 0; w < 16; w++) msg_blk[3][w] = $urandom;
      for (int i = 0; i < 8; i++) pr[32*i +: 32] = $urandom;
      wv_r = expand_blk(3);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      start_run("rand", pr, wv_r);
      finish_run("rand", model(pr, wv_r), -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
